// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib iterative accumulator.
package fib_pkg;
  localparam int N_W = 6;
  localparam int D_W = 32;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef logic [N_W-1:0] count_t;
  typedef logic [D_W-1:0] data_t;
endpackage

// File: rtl/fib_step.sv
// One combinational iteration step: (n, a, b) -> (n-1, a+b, a), with done when n is 0.
module fib_step #(
  parameter int N_W = fib_pkg::N_W,
  parameter int D_W = fib_pkg::D_W
) (
  input  logic [N_W-1:0] n,
  input  logic [D_W-1:0] a,
  input  logic [D_W-1:0] b,
  output logic [N_W-1:0] n_nx,
  output logic [D_W-1:0] a_nx,
  output logic [D_W-1:0] b_nx,
  output logic           done
);
  assign done = (n == '0);
  assign n_nx = n - N_W'(1);
  assign a_nx = a + b;
  assign b_nx = a;
endmodule

// File: rtl/fib_main.sv
// Iterative Fibonacci-style accumulator: start latches (n, a, b), one step per clock,
// result and a one-cycle w_enable strobe when n reaches zero.
//
// state | meaning
// IDLE  | waiting for r_enable; result holds the last completed value
// RUN   | stepping once per clock unless controlArr stalls; completes when n == 0
import fib_pkg::*;

module fib_main #(
  parameter int N_W = fib_pkg::N_W,
  parameter int D_W = fib_pkg::D_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r_enable,
  input  logic           controlArr,
  input  logic [N_W-1:0] init_n,
  input  logic [D_W-1:0] init_a,
  input  logic [D_W-1:0] init_b,
  output logic           w_enable,
  output logic [D_W-1:0] result
);
  state_t         state, state_nx;
  logic [N_W-1:0] n_q, n_d, n_step;
  logic [D_W-1:0] a_q, a_d, a_step;
  logic [D_W-1:0] b_q, b_d, b_step;
  logic [D_W-1:0] result_d;
  logic           w_enable_d;
  logic           done;

  fib_step #(.N_W(N_W), .D_W(D_W)) u_step (
    .n    (n_q),
    .a    (a_q),
    .b    (b_q),
    .n_nx (n_step),
    .a_nx (a_step),
    .b_nx (b_step),
    .done (done)
  );

  always_comb begin
    state_nx   = state;
    n_d        = n_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result;
    w_enable_d = 1'b0;
    case (state)
      IDLE: begin
        if (r_enable) begin
          n_d      = init_n;
          a_d      = init_a;
          b_d      = init_b;
          state_nx = RUN;
        end
      end
      RUN: begin
        // a stall freezes everything, including a pending completion
        if (!controlArr) begin
          if (done) begin
            result_d   = b_q;
            w_enable_d = 1'b1;
            state_nx   = IDLE;
          end else begin
            n_d = n_step;
            a_d = a_step;
            b_d = b_step;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      w_enable <= 1'b0;
    end else begin
      state    <= state_nx;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result   <= result_d;
      w_enable <= w_enable_d;
    end
  end
endmodule

// File: tb/tb_fib_main.sv
// Self-checking bench for fib_main: directed cases plus randomized runs with stalls.
module tb_fib_main;
  logic        clk;
  logic        rst_n;
  logic        r_enable;
  logic        control_arr;
  logic [5:0]  init_n;
  logic [31:0] init_a;
  logic [31:0] init_b;
  logic        w_enable;
  logic [31:0] result;

  int          vectors;
  int          miscompares;
  logic [31:0] last_res;

  fib_main dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_enable   (r_enable),
    .controlArr (control_arr),
    .init_n     (init_n),
    .init_a     (init_a),
    .init_b     (init_b),
    .w_enable   (w_enable),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Closed form: after n steps b = a*F(n) + b0*F(n-1), with F(-1) = 1, all mod 2^32.
  function automatic logic [31:0] ref_res(input int n, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] fm [0:64];
    fm[0] = 32'd1;
    fm[1] = 32'd0;
    for (int i = 2; i <= 64; i++) fm[i] = fm[i-1] + fm[i-2];
    return a * fm[n+1] + b * fm[n];
  endfunction

  // stall_mode: 0 none, 1 stall edges 4..8, 2 random
  task automatic run_case(input string name, input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int stall_mode,
                          input bit poke, input bit b2b);
    int  prog;
    int  model_edge;
    int  got;
    bit  stall;
    r_enable    = 1'b1;
    init_n      = 6'(n);
    init_a      = a;
    init_b      = b;
    control_arr = 1'($urandom % 2);
    tick();
    r_enable = 1'b0;
    init_n   = 6'($urandom);
    init_a   = $urandom;
    init_b   = $urandom;
    vectors++;
    if (w_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start_wen: got %b want 0", name, w_enable);
    end
    prog = 0;
    model_edge = 0;
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      case (stall_mode)
        1:       stall = (k >= 4 && k <= 8);
        2:       stall = ($urandom % 3 == 0);
        default: stall = 1'b0;
      endcase
      control_arr = stall;
      if (model_edge == 0) begin
        if (!stall) prog++;
        if (prog == n + 1) model_edge = k;
      end
      if (poke && (model_edge == 0 || model_edge == k)) begin
        r_enable = 1'($urandom % 2);
        init_n   = 6'($urandom);
        init_a   = $urandom;
        init_b   = $urandom;
      end else begin
        r_enable = 1'b0;
      end
      tick();
      if (w_enable === 1'b1) begin
        got = k;
        break;
      end
      vectors++;
      if (result !== last_res) begin
        miscompares++;
        $display("FAIL %s held_result: edge %0d got %0d want %0d", name, k, result, last_res);
      end
    end
    r_enable    = 1'b0;
    control_arr = 1'b0;
    if (exp_lat < 0) exp_lat = model_edge;
    vectors++;
    if (got !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d (0 = no strobe)", name, got, exp_lat);
    end
    vectors++;
    if (result !== exp_res) begin
      miscompares++;
      $display("FAIL %s result: got %0d want %0d", name, result, exp_res);
    end
    last_res = exp_res;
    if (!b2b) begin
      control_arr = 1'($urandom % 2);
      tick();
      control_arr = 1'b0;
      vectors++;
      if (w_enable !== 1'b0 || result !== last_res) begin
        miscompares++;
        $display("FAIL %s after_done: wen %b result %0d want wen 0 result %0d", name, w_enable, result, last_res);
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    r_enable    = 1'b0;
    control_arr = 1'b0;
    init_n      = '0;
    init_a      = '0;
    init_b      = '0;
    last_res    = '0;
    repeat (3) tick();
    vectors++;
    if (w_enable !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: wen %b result %0d want 0 0", w_enable, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_case("fib40", 40, 32'd1, 32'd0, 32'd102334155, 41, 0, 1'b0, 1'b0);
    run_case("n0", 0, 32'd9, 32'd7, 32'd7, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_case("b2b_first", 1, 32'd5, 32'd3, 32'd5, 2, 0, 1'b0, 1'b1);
    run_case("b2b_second", 3, 32'd1, 32'd0, 32'd2, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_case("wrap63", 63, 32'd1, 32'd0, 32'd3350226146, 64, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_case("stall10", 10, 32'd1, 32'd0, 32'd55, 16, 1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    r_enable = 1'b1;
    init_n   = 6'd40;
    init_a   = 32'd1;
    init_b   = 32'd0;
    tick();
    r_enable = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    last_res = '0;
    vectors++;
    if (w_enable !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: wen %b result %0d want 0 0", w_enable, result);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      tick();
      if (w_enable !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL aborted_run_strobe: got strobe %b want 0", seen);
    end
    run_case("after_reset", 2, 32'd1, 32'd0, 32'd1, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 63);
      a = $urandom;
      b = $urandom;
      run_case("random", n, a, b, ref_res(n, a, b), -1, 2, 1'b1, 1'($urandom % 2));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_wrap();
    test_stall();
    test_reset_mid_run();
    test_random();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
